// File: rtl/bus_controller.sv
// Bus controller: runs one master request at a time onto a one-hot device bus,
// waits for the device ack (bounded by TIMEOUT) and reports a one-cycle done strobe.
module bus_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] phys_addr,
  input  logic [7:0]  device_en,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [7:0]  dev_en,
  output logic [31:0] dev_addr,
  output logic        dev_we,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [7:0]    en_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic          oneHot;

  assign oneHot = (device_en != 8'd0) && ((device_en & (device_en - 8'd1)) == 8'd0);

  // Saturating increment: the counter never wraps even if held in ACCESS.
  assign cnt_d = (cnt_q == TLIM) ? cnt_q : cnt_q + CW'(1);

  // The device-side registers double as the request latch, so the bus
  // sees the latched request directly and stays stable through ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            cnt_q   <= '0;
            addr_q  <= phys_addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (oneHot) begin
              state_q <= ACCESS;
              en_q    <= device_en;
              we_q    <= we;
            end else begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!dev_ack) begin
            cnt_q <= cnt_d;
          end
          // Ack beats a timeout landing on the same edge.
          if (dev_ack || (cnt_d == TLIM)) begin
            state_q <= RESP;
            done_q  <= 1'b1;
            err_q   <= ~dev_ack;
            rdata_q <= (dev_ack && !we_q) ? dev_rdata : 32'd0;
            en_q    <= '0;
            we_q    <= 1'b0;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          en_q    <= '0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign dev_en    = en_q;
  assign dev_addr  = addr_q;
  assign dev_we    = we_q;
  assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: a driver pushes expected results computed
// from the transaction rules, a monitor pops and compares on every done strobe.
module tb_bus_controller;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] phys_addr;
  logic [7:0]  device_en;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [7:0]  dev_en;
  logic [31:0] dev_addr;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  bus_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .phys_addr (phys_addr),
    .device_en (device_en),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .dev_en    (dev_en),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .dev_ack   (dev_ack),
    .dev_rdata (dev_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  en;
    logic [31:0] wdata;
    int          ackAt;
    logic [31:0] rd;
    logic        expErr;
    logic [31:0] expRdata;
    int          expAcc;
    int          expLat;
    int          sampleCyc;
  } txn_t;

  txn_t expQ[$];
  int   testsRun;
  int   testsFailed;
  int   cycleCnt;
  int   lastDoneCyc;
  int   accSeen;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cycleCnt    = 0;
    lastDoneCyc = 0;
    accSeen     = 0;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  // Reference outcome of a transaction, straight from the transaction rules:
  // bad select -> error next cycle; ack within the window -> success;
  // otherwise the window expires after TIMEOUT access cycles with an error.
  function automatic void buildExpect(inout txn_t t);
    if ($countones(t.en) != 1) begin
      t.expErr   = 1'b1;
      t.expRdata = 32'd0;
      t.expAcc   = 0;
      t.expLat   = 1;
    end else if (t.ackAt >= 1 && t.ackAt <= TIMEOUT) begin
      t.expErr   = 1'b0;
      t.expRdata = t.we ? 32'd0 : t.rd;
      t.expAcc   = t.ackAt;
      t.expLat   = t.ackAt + 1;
    end else begin
      t.expErr   = 1'b1;
      t.expRdata = 32'd0;
      t.expAcc   = TIMEOUT;
      t.expLat   = TIMEOUT + 1;
    end
  endfunction

  function automatic txn_t mkTxn(input logic w, input logic [31:0] a, input logic [7:0] e,
                                 input logic [31:0] d, input int ack, input logic [31:0] r);
    txn_t t;
    t.we = w; t.addr = a; t.en = e; t.wdata = d; t.ackAt = ack; t.rd = r;
    t.expErr = 1'b0; t.expRdata = 32'd0; t.expAcc = 0; t.expLat = 0; t.sampleCyc = 0;
    return t;
  endfunction

  task automatic driveInputs(input txn_t t);
    we        = t.we;
    phys_addr = t.addr;
    device_en = t.en;
    wdata     = t.wdata;
    req       = 1'b1;
  endtask

  // chained: req was left high by the previous call and the new request must
  // be taken on the edge that closes the first IDLE cycle after done.
  task automatic applyStimulus(input txn_t t, input bit chained, input int gap, input bit keepReq);
    int guard;
    guard = 0;
    if (chained) driveInputs(t);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("idle_wait_busy", 32'(busy), 32'd0);
      req = 1'b0;
      return;
    end
    if (!chained) begin
      repeat (gap) @(negedge clk);
      driveInputs(t);
    end
    @(posedge clk);
    #1;
    t.sampleCyc = cycleCnt;
    buildExpect(t);
    expQ.push_back(t);
    checkOutput("accept_busy", 32'(busy), 32'd1);
    if (chained) checkOutput("chain_accept_cycle", 32'(t.sampleCyc), 32'(lastDoneCyc + 2));
    if (!keepReq) req = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  32'(busy),   32'd0);
    checkOutput({tag, "_done"},  32'(done),   32'd0);
    checkOutput({tag, "_err"},   32'(err),    32'd0);
    checkOutput({tag, "_rdata"}, rdata,       32'd0);
    checkOutput({tag, "_dev_en"}, 32'(dev_en), 32'd0);
    checkOutput({tag, "_dev_addr"}, dev_addr, 32'd0);
    checkOutput({tag, "_dev_we"}, 32'(dev_we), 32'd0);
    checkOutput({tag, "_dev_wdata"}, dev_wdata, 32'd0);
  endtask

  // Device model: acks on the requested access cycle, random noise otherwise.
  initial begin
    int accCnt;
    accCnt    = 0;
    dev_ack   = 1'b0;
    dev_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (dev_en != 8'd0 && expQ.size() != 0) begin
        accCnt++;
        if (accCnt == expQ[0].ackAt) begin
          dev_ack   = 1'b1;
          dev_rdata = expQ[0].rd;
        end else begin
          dev_ack   = 1'b0;
          dev_rdata = $urandom;
        end
      end else begin
        accCnt    = 0;
        dev_ack   = 1'($urandom_range(0, 1));
        dev_rdata = $urandom;
      end
    end
  end

  // Monitor: per-cycle bus checks plus scoreboard pop on done.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      checkOutput("busy", 32'(busy), 32'(expQ.size() != 0));
      if (dev_en != 8'd0) begin
        if (expQ.size() == 0) begin
          checkOutput("dev_en_unexpected", 32'(dev_en), 32'd0);
        end else begin
          checkOutput("dev_en", 32'(dev_en), 32'(expQ[0].en));
          checkOutput("dev_addr", dev_addr, expQ[0].addr);
          checkOutput("dev_we", 32'(dev_we), 32'(expQ[0].we));
          checkOutput("dev_wdata", dev_wdata, expQ[0].wdata);
          accSeen++;
        end
      end else begin
        checkOutput("dev_we_idle", 32'(dev_we), 32'd0);
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", 32'(done), 32'd0);
        end else begin
          t = expQ.pop_front();
          checkOutput("err", 32'(err), 32'(t.expErr));
          checkOutput("rdata", rdata, t.expRdata);
          checkOutput("access_cycles", 32'(accSeen), 32'(t.expAcc));
          checkOutput("latency", 32'(cycleCnt - t.sampleCyc + 1), 32'(t.expLat));
          accSeen     = 0;
          lastDoneCyc = cycleCnt;
        end
      end else begin
        checkOutput("err_idle", 32'(err), 32'd0);
        checkOutput("rdata_idle", rdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t        t;
    bit          keepPrev;
    bit          keep;
    int          guard;
    int          r;
    logic [7:0]  one;
    logic [7:0]  en;

    rst_n = 1'b0; req = 1'b0; we = 1'b0;
    phys_addr = 32'd0; device_en = 8'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    applyStimulus(mkTxn(1'b0, 32'h0000_00A0, 8'h02, 32'h0, 3, 32'hDEADBEEF), 1'b0, 0, 1'b0);
    applyStimulus(mkTxn(1'b1, 32'h0000_0040, 8'h01, 32'h1234_5678, 1, 32'h5555_AAAA), 1'b0, 1, 1'b0);
    applyStimulus(mkTxn(1'b0, 32'h0000_0080, 8'h04, 32'h0, 0, 32'h0BAD_0BAD), 1'b0, 2, 1'b0);
    applyStimulus(mkTxn(1'b0, 32'h0000_0010, 8'h00, 32'h0, 1, 32'h1111_1111), 1'b0, 0, 1'b0);
    applyStimulus(mkTxn(1'b1, 32'h0000_0020, 8'h03, 32'hFFFF_0000, 1, 32'h2222_2222), 1'b0, 0, 1'b0);
    applyStimulus(mkTxn(1'b0, 32'h0000_0300, 8'h10, 32'h0, TIMEOUT, 32'hA5A5_5A5A), 1'b0, 0, 1'b1);
    applyStimulus(mkTxn(1'b1, 32'h0000_0304, 8'h40, 32'hC0DE_0001, 2, 32'h3333_3333), 1'b1, 0, 1'b0);

    // Reset dropped in the second access cycle of a transaction that never acks.
    applyStimulus(mkTxn(1'b1, 32'h0000_0C00, 8'h08, 32'h7777_7777, 0, 32'h0), 1'b0, 1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    accSeen = 0;
    #1;
    checkAllZero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkTxn(1'b0, 32'h0000_0100, 8'h20, 32'h0, 2, 32'hCAFE_F00D), 1'b0, 0, 1'b0);

    keepPrev = 1'b0;
    one      = 8'h01;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        en = one << $urandom_range(0, 7);
      end else if (r == 7) begin
        en = 8'h00;
      end else begin
        en = 8'($urandom);
        while ($countones(en) < 2) en = 8'($urandom);
      end
      keep = (i != 39) && ($urandom_range(0, 3) == 0);
      t = mkTxn(1'($urandom_range(0, 1)), $urandom, en, $urandom,
                $urandom_range(0, TIMEOUT + 1), $urandom);
      applyStimulus(t, keepPrev, $urandom_range(0, 2), keep);
      keepPrev = keep;
    end

    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
